// File: rtl/pulse_pkg.sv
// Shared pulse measurement types: FSM state encoding and default counter width.
// Also imported by the pulse-generator bench.
package pulse_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StMeasure = 2'd2
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single-bit level, resetting to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/pulse_measure.sv
// Measures the high width of pulse in clk cycles, reporting cnt/ovf with a valid strobe.
// Define PULSE_MEASURE_SYNC_EN to pass pulse through a two-flop synchronizer first.
module pulse_measure
  import pulse_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             valid,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] CountMax = '1;

  logic w_pulse;

`ifdef PULSE_MEASURE_SYNC_EN
  sync2 u_sync2 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pulse),
    .q    (w_pulse)
  );
`else
  assign w_pulse = pulse;
`endif

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic             r_valid;
  logic             w_valid_next;
  logic             r_ovf;
  logic             w_ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_count <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_cnt   <= w_cnt_next;
      r_valid <= w_valid_next;
      r_ovf   <= w_ovf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_cnt_next   = r_cnt;
    w_valid_next = 1'b0;
    w_ovf_next   = r_ovf;
    // Disable wins over everything, including a completing measurement.
    if (!en) begin
      w_state_next = StIdle;
      w_count_next = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Only arm on a low sample so a pulse already in flight is skipped.
          if (!w_pulse) w_state_next = StArmed;
        end
        StArmed: begin
          if (w_pulse) begin
            w_state_next = StMeasure;
            w_count_next = WIDTH'(1);
          end
        end
        StMeasure: begin
          if (w_pulse) begin
            if (r_count != CountMax) w_count_next = r_count + WIDTH'(1);
          end else begin
            w_state_next = StArmed;
            w_cnt_next   = r_count;
            w_valid_next = 1'b1;
            w_ovf_next   = (r_count == CountMax);
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign cnt   = r_cnt;
  assign valid = r_valid;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_pulse_measure.sv
// Directed bench for pulse_measure: an 8-bit and a 4-bit instance share clk, reset and stimulus.
module tb_pulse_measure;

`ifdef PULSE_MEASURE_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pulse;
  logic       en;
  logic [7:0] cnt8;
  logic       valid8;
  logic       ovf8;
  logic [3:0] cnt4;
  logic       valid4;
  logic       ovf4;

  int n_cmp = 0;
  int n_err = 0;

  int         nv8 = 0;
  int         nv4 = 0;
  logic [7:0] q8[$];

  always #5 clk = ~clk;

  pulse_measure #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .pulse(pulse),
    .en   (en),
    .cnt  (cnt8),
    .valid(valid8),
    .ovf  (ovf8)
  );

  pulse_measure #(.WIDTH(4)) u_dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .pulse(pulse),
    .en   (en),
    .cnt  (cnt4),
    .valid(valid4),
    .ovf  (ovf4)
  );

  // Strobe monitor: reads pre-edge values, so it sees each valid cycle exactly once.
  always @(posedge clk) begin
    if (valid8) begin
      nv8++;
      q8.push_back(cnt8);
    end
    if (valid4) nv4++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Each value is set just after a negedge, so exactly one posedge samples it.
  task automatic drive(input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      pulse = p;
      @(negedge clk);
    end
  endtask

  task automatic clear_mon();
    nv8 = 0;
    nv4 = 0;
    q8.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    pulse = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cnt", 32'(cnt8), 0);
    check("reset_valid", 32'(valid8), 0);
    check("reset_ovf", 32'(ovf8), 0);
    rst_n = 1'b1;
    en    = 1'b1;
    drive(1'b0, 2);

    // Loopback of a 9-cycle generated pulse, with exact valid latency.
    clear_mon();
    drive(1'b1, 9);
    pulse = 1'b0;
    for (int i = 0; i < Lat; i++) begin
      @(negedge clk);
      check("loop_valid_early", 32'(valid8), 0);
    end
    @(negedge clk);
    check("loop_valid", 32'(valid8), 1);
    check("loop_cnt", 32'(cnt8), 9);
    check("loop_ovf", 32'(ovf8), 0);
    drive(1'b0, 4);
    check("loop_nvalid", 32'(nv8), 1);
    check("loop_cnt_hold", 32'(cnt8), 9);

    // Single-cycle pulse.
    clear_mon();
    drive(1'b1, 1);
    drive(1'b0, 4 + Lat);
    check("single_nvalid", 32'(nv8), 1);
    check("single_cnt", 32'(cnt8), 1);

    // Back-to-back 3 and 5 with one low sample between.
    clear_mon();
    drive(1'b1, 3);
    drive(1'b0, 1);
    drive(1'b1, 5);
    drive(1'b0, 4 + Lat);
    check("b2b_nvalid", 32'(nv8), 2);
    check("b2b_first", (q8.size() > 0) ? 32'(q8[0]) : 32'hdead, 3);
    check("b2b_second", (q8.size() > 1) ? 32'(q8[1]) : 32'hdead, 5);

    // 20-cycle pulse saturates the 4-bit counter but not the 8-bit one.
    clear_mon();
    drive(1'b1, 20);
    drive(1'b0, 4 + Lat);
    check("sat_nvalid4", 32'(nv4), 1);
    check("sat_cnt4", 32'(cnt4), 15);
    check("sat_ovf4", 32'(ovf4), 1);
    check("sat_cnt8", 32'(cnt8), 20);
    check("sat_ovf8", 32'(ovf8), 0);
    clear_mon();
    drive(1'b1, 2);
    drive(1'b0, 4 + Lat);
    check("post_sat_nvalid4", 32'(nv4), 1);
    check("post_sat_cnt4", 32'(cnt4), 2);
    check("post_sat_ovf4", 32'(ovf4), 0);

    // en drop mid-pulse, then en returns while pulse is still high.
    clear_mon();
    pulse = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, 2);
    en = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 4 + Lat);
    check("endrop_nvalid", 32'(nv8), 0);
    check("endrop_cnt_hold", 32'(cnt8), 2);
    drive(1'b1, 3);
    drive(1'b0, 4 + Lat);
    check("endrop_recover_nvalid", 32'(nv8), 1);
    check("endrop_recover_cnt", 32'(cnt8), 3);

    // Asynchronous reset in the middle of a 10-cycle pulse.
    clear_mon();
    drive(1'b1, 4);
    rst_n = 1'b0;
    // The synchronizer restarts at 0, so keep en low until it has caught the high level.
    en = (Lat == 0);
    #1;
    check("rst_async_cnt8", 32'(cnt8), 0);
    check("rst_async_cnt4", 32'(cnt4), 0);
    check("rst_async_valid", 32'(valid8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3);
    en = 1'b1;
    drive(1'b1, 2);
    drive(1'b0, 4 + Lat);
    check("rst_nvalid", 32'(nv8), 0);
    check("rst_cnt_hold", 32'(cnt8), 0);
    drive(1'b1, 4);
    drive(1'b0, 4 + Lat);
    check("rst_recover_nvalid", 32'(nv8), 1);
    check("rst_recover_cnt", 32'(cnt8), 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
PULSE_MEASURE -- requirements
Module: pulse_measure

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bit width of the measured-count output and internal counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; all state changes on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port pulse  input  1  pulse to be measured, level-sampled on posedge clk.
REQ-005 SHALL have port en  input  1  measurement enable; low aborts and idles the block.
REQ-006 SHALL have port cnt  output  WIDTH  width of the last completed pulse, in clk cycles.
REQ-007 SHALL have port valid  output  1  one-cycle strobe marking a new cnt value.
REQ-008 SHALL have port ovf  output  1  set with valid when the measured pulse saturated the counter.

Function
REQ-009 SHALL implement a three-state FSM: IDLE, ARMED, MEASURE.
REQ-010 IDLE -> ARMED SHALL occur on the edge where en=1 and sampled pulse=0; a pulse already high when en rises SHALL be ignored until it returns low.
REQ-011 ARMED -> MEASURE SHALL occur on the edge where sampled pulse=1; the internal counter SHALL load 1 on that edge.
REQ-012 In MEASURE, each edge sampling pulse=1 SHALL increment the counter by 1, saturating at 2^WIDTH-1 (no wrap).
REQ-013 In MEASURE, the first edge sampling pulse=0 SHALL load cnt with the counter value, set valid=1 for exactly one cycle, set ovf=1 iff the counter was saturated, and return to ARMED.
REQ-014 Reported width SHALL equal the number of consecutive posedges sampling pulse=1; a one-cycle pulse SHALL report cnt=1.
REQ-015 Back-to-back pulses separated by one low sample SHALL both be measured (ARMED -> MEASURE on the next high sample).
REQ-016 en=0 on any edge SHALL force IDLE and clear the internal counter; an in-progress measurement SHALL be discarded with no valid.
REQ-017 cnt and ovf SHALL hold their values between valid strobes; valid SHALL be 0 in every cycle except the completion cycle.
REQ-018 Latency (without REQ-022): valid SHALL assert in the cycle after the posedge that first samples the falling pulse level.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, cnt=0, valid=0, ovf=0.
REQ-020 Reset asserted mid-measurement SHALL discard the measurement; after release the block SHALL require en=1 and a low pulse sample before measuring.
REQ-021 Release of rst_n SHALL take effect on the next posedge clk; no output SHALL change before that edge except via reset.

Configuration
REQ-022 Macro PULSE_MEASURE_SYNC_EN defined SHALL insert a two-flop synchronizer on pulse before the FSM, adding exactly 2 cycles of latency to every transition driven by pulse; reported widths SHALL be unchanged.
REQ-023 Macro PULSE_MEASURE_SYNC_EN undefined SHALL feed pulse directly to the FSM; pulse SHALL then be synchronous to clk.

Structure
REQ-024 State encodings (IDLE=2'd0, ARMED=2'd1, MEASURE=2'd2) and default WIDTH SHALL reside in shared package pulse_pkg, also usable by the existing pulse-generator bench.
REQ-025 The synchronizer SHALL be sub-module sync2 (clk, rst_n, d, q; reset value 0), instantiated only under PULSE_MEASURE_SYNC_EN.

Verification
REQ-026 Loopback: count_pulse WIDTH=8 loaded with 9, output driving pulse, en=1 -> one valid, cnt=9, ovf=0.
REQ-027 Single-cycle pulse high for 1 cycle -> valid once, cnt=1; pulses of 3 cycles, 1 cycle low, then 5 cycles high -> cnt=3, then cnt=5.
REQ-028 WIDTH=4 with pulse high 20 cycles -> valid once after fall, cnt=15, ovf=1; next pulse of 2 cycles -> cnt=2, ovf=0.
REQ-029 en drop: pulse high 6 cycles, en=0 at cycle 3 -> no valid, cnt keeps prior value; en=1 with pulse already high -> no valid until a full low-high-low cycle.
REQ-030 Reset mid-measure: rst_n=0 during a 10-cycle pulse -> cnt=0, valid=0 immediately (asynchronous), no valid from that pulse.
REQ-031 Repeat REQ-026 with PULSE_MEASURE_SYNC_EN defined -> cnt=9 and valid delayed by exactly 2 cycles relative to the undefined build.
